// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter and functional-unit occupancy tracker.
// Collects completion requests from every functional unit, grants one per
// cycle onto the single register/predicate writeback port, and exports the
// per-unit busy state to decode as free_units.
// Optional build macro: WB_ARB_FIXED_PRIORITY_EN selects fixed priority
// (lowest eligible index wins) instead of the default round-robin.
`timescale 1ns/1ps

module wb_arbiter #(
  parameter int FUNC_UNIT_OP_SIZE = 3,
  parameter int REG_ADDR_SIZE     = 4,
  parameter int PRED_ADDR_SIZE    = 2,
  parameter int DATA_WIDTH        = 32
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           issue,
  input  logic [FUNC_UNIT_OP_SIZE-1:0]                   issue_unit,
  input  logic [(1<<FUNC_UNIT_OP_SIZE)-1:0]              unit_done,
  input  logic [(1<<FUNC_UNIT_OP_SIZE)*REG_ADDR_SIZE-1:0]  unit_reg_addr,
  input  logic [(1<<FUNC_UNIT_OP_SIZE)-1:0]              unit_reg_valid,
  input  logic [(1<<FUNC_UNIT_OP_SIZE)*PRED_ADDR_SIZE-1:0] unit_pred_addr,
  input  logic [(1<<FUNC_UNIT_OP_SIZE)-1:0]              unit_pred_valid,
  input  logic [(1<<FUNC_UNIT_OP_SIZE)*DATA_WIDTH-1:0]     unit_data,
  output logic [(1<<FUNC_UNIT_OP_SIZE)-1:0]              unit_ack,
  output logic                                           wr_reg,
  output logic [REG_ADDR_SIZE-1:0]                       wr_reg_addr,
  output logic                                           wr_pred,
  output logic [PRED_ADDR_SIZE-1:0]                      wr_pred_addr,
  output logic [DATA_WIDTH-1:0]                          wr_data,
  output logic [FUNC_UNIT_OP_SIZE-1:0]                   wb_unit_id,
  output logic [(1<<FUNC_UNIT_OP_SIZE)-1:0]              free_units
);

  localparam int NUM_UNITS = 1 << FUNC_UNIT_OP_SIZE;

  logic [NUM_UNITS-1:0]         busy;
  logic [NUM_UNITS-1:0]         busy_next;
  logic [NUM_UNITS-1:0]         req;
  logic [FUNC_UNIT_OP_SIZE-1:0] search_base;
  logic [FUNC_UNIT_OP_SIZE-1:0] cand;
  logic                         grant_valid;
  logic [FUNC_UNIT_OP_SIZE-1:0] grant_idx;

  logic [REG_ADDR_SIZE-1:0]     sel_reg_addr;
  logic                         sel_reg_valid;
  logic [PRED_ADDR_SIZE-1:0]    sel_pred_addr;
  logic                         sel_pred_valid;
  logic [DATA_WIDTH-1:0]        sel_data;

  // Only units we know are busy may complete; a stray done is never acked.
  assign req        = unit_done & busy;
  assign free_units = ~busy;

`ifdef WB_ARB_FIXED_PRIORITY_EN
  // Fixed priority: the search always starts at unit 0.
  assign search_base = '0;
`else
  logic [FUNC_UNIT_OP_SIZE-1:0] rr_ptr;

  assign search_base = rr_ptr;

  // Round-robin pointer moves to the unit just after the one granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= grant_idx + FUNC_UNIT_OP_SIZE'(1);
    end
  end
`endif

  // Pick the first eligible request starting at search_base, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      cand = search_base + FUNC_UNIT_OP_SIZE'(i);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // One-hot grant back to the winning unit, suppressed while in reset.
  always_comb begin
    unit_ack = '0;
    if (grant_valid && !reset) begin
      unit_ack[grant_idx] = 1'b1;
    end
  end

  // Route the winning unit's payload toward the writeback registers.
  always_comb begin
    sel_reg_addr   = '0;
    sel_reg_valid  = 1'b0;
    sel_pred_addr  = '0;
    sel_pred_valid = 1'b0;
    sel_data       = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (grant_idx == FUNC_UNIT_OP_SIZE'(k)) begin
        sel_reg_addr   = unit_reg_addr[k*REG_ADDR_SIZE +: REG_ADDR_SIZE];
        sel_reg_valid  = unit_reg_valid[k];
        sel_pred_addr  = unit_pred_addr[k*PRED_ADDR_SIZE +: PRED_ADDR_SIZE];
        sel_pred_valid = unit_pred_valid[k];
        sel_data       = unit_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Busy update: a grant frees its unit, an issue claims one; issue wins a tie.
  always_comb begin
    busy_next = busy;
    if (grant_valid) begin
      busy_next[grant_idx] = 1'b0;
    end
    if (issue) begin
      busy_next[issue_unit] = 1'b1;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Writeback port: strobes pulse for one cycle, payload holds between grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_reg       <= 1'b0;
      wr_pred      <= 1'b0;
      wr_reg_addr  <= '0;
      wr_pred_addr <= '0;
      wr_data      <= '0;
      wb_unit_id   <= '0;
    end else begin
      wr_reg  <= 1'b0;
      wr_pred <= 1'b0;
      if (grant_valid) begin
        wr_reg       <= sel_reg_valid;
        wr_pred      <= sel_pred_valid;
        wr_reg_addr  <= sel_reg_addr;
        wr_pred_addr <= sel_pred_addr;
        wr_data      <= sel_data;
        wb_unit_id   <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: vector table plus writeback scoreboard for wb_arbiter.
`timescale 1ns/1ps

module tb_wb_arbiter;

  typedef struct {
    string      name;
    logic       issue;
    logic [2:0] iu;
    logic [7:0] done;
    logic [7:0] ack;
  } vec_t;

  typedef struct {
    logic        wr_reg;
    logic [3:0]  wr_reg_addr;
    logic        wr_pred;
    logic [1:0]  wr_pred_addr;
    logic [31:0] wr_data;
    logic [2:0]  wb_unit_id;
  } wb_t;

  logic        clk;
  logic        reset;
  logic        issue;
  logic [2:0]  issue_unit;
  logic [7:0]  unit_done;
  logic [31:0] unit_reg_addr;
  logic [7:0]  unit_reg_valid;
  logic [15:0] unit_pred_addr;
  logic [7:0]  unit_pred_valid;
  logic [255:0] unit_data;
  logic [7:0]  unit_ack;
  logic        wr_reg;
  logic [3:0]  wr_reg_addr;
  logic        wr_pred;
  logic [1:0]  wr_pred_addr;
  logic [31:0] wr_data;
  logic [2:0]  wb_unit_id;
  logic [7:0]  free_units;

  logic [3:0]  pay_reg   [8];
  logic [1:0]  pay_pred  [8];
  logic [31:0] pay_data  [8];

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  m_busy;
  wb_t         last_wb;
  wb_t         sb_q [$];
  vec_t        vecs [$];

  wb_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .issue           (issue),
    .issue_unit      (issue_unit),
    .unit_done       (unit_done),
    .unit_reg_addr   (unit_reg_addr),
    .unit_reg_valid  (unit_reg_valid),
    .unit_pred_addr  (unit_pred_addr),
    .unit_pred_valid (unit_pred_valid),
    .unit_data       (unit_data),
    .unit_ack        (unit_ack),
    .wr_reg          (wr_reg),
    .wr_reg_addr     (wr_reg_addr),
    .wr_pred         (wr_pred),
    .wr_pred_addr    (wr_pred_addr),
    .wr_data         (wr_data),
    .wb_unit_id      (wb_unit_id),
    .free_units      (free_units)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flatten the per-unit payload tables onto the DUT buses.
  always_comb begin
    unit_reg_addr  = '0;
    unit_pred_addr = '0;
    unit_data      = '0;
    for (int k = 0; k < 8; k++) begin
      unit_reg_addr[k*4 +: 4]   = pay_reg[k];
      unit_pred_addr[k*2 +: 2]  = pay_pred[k];
      unit_data[k*32 +: 32]     = pay_data[k];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic iss, input logic [2:0] iu,
                              input logic [7:0] done, input logic [7:0] ack);
    vec_t v;
    v.name  = name;
    v.issue = iss;
    v.iu    = iu;
    v.done  = done;
    v.ack   = ack;
    return v;
  endfunction

  // Pops the expected writeback and compares the registered outputs.
  task automatic checkOutput(input string name);
    wb_t e;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({name, "_wr_reg"},       {31'd0, wr_reg},       {31'd0, e.wr_reg});
      check({name, "_wr_reg_addr"},  {28'd0, wr_reg_addr},  {28'd0, e.wr_reg_addr});
      check({name, "_wr_pred"},      {31'd0, wr_pred},      {31'd0, e.wr_pred});
      check({name, "_wr_pred_addr"}, {30'd0, wr_pred_addr}, {30'd0, e.wr_pred_addr});
      check({name, "_wr_data"},      wr_data,               e.wr_data);
      check({name, "_wb_unit_id"},   {29'd0, wb_unit_id},   {29'd0, e.wb_unit_id});
    end
    check({name, "_free_units"}, {24'd0, free_units}, {24'd0, ~m_busy});
  endtask

  // Drives one cycle of stimulus, checks the grant, pushes the expected writeback.
  task automatic applyStimulus(input vec_t v);
    wb_t e;
    int  k;
    issue      = v.issue;
    issue_unit = v.iu;
    unit_done  = v.done;
    #1;
    check({v.name, "_unit_ack"}, {24'd0, unit_ack}, {24'd0, v.ack});
    k = -1;
    for (int i = 0; i < 8; i++) if (v.ack[i]) k = i;
    if (k >= 0) begin
      e.wr_reg       = unit_reg_valid[k];
      e.wr_pred      = unit_pred_valid[k];
      e.wr_reg_addr  = pay_reg[k];
      e.wr_pred_addr = pay_pred[k];
      e.wr_data      = pay_data[k];
      e.wb_unit_id   = 3'(k);
      last_wb        = e;
      m_busy[k]      = 1'b0;
    end else begin
      e         = last_wb;
      e.wr_reg  = 1'b0;
      e.wr_pred = 1'b0;
    end
    if (v.issue) m_busy[v.iu] = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(v.name);
  endtask

  initial begin
    pay_reg[0] = 4'h1; pay_pred[0] = 2'd0; pay_data[0] = 32'h1000_0000;
    pay_reg[1] = 4'h9; pay_pred[1] = 2'd1; pay_data[1] = 32'h1111_1111;
    pay_reg[2] = 4'h2; pay_pred[2] = 2'd2; pay_data[2] = 32'h2222_2222;
    pay_reg[3] = 4'h5; pay_pred[3] = 2'd0; pay_data[3] = 32'hDEAD_BEEF;
    pay_reg[4] = 4'hA; pay_pred[4] = 2'd1; pay_data[4] = 32'h4444_4444;
    pay_reg[5] = 4'h3; pay_pred[5] = 2'd3; pay_data[5] = 32'h5555_5555;
    pay_reg[6] = 4'hC; pay_pred[6] = 2'd3; pay_data[6] = 32'h6666_6666;
    pay_reg[7] = 4'h6; pay_pred[7] = 2'd2; pay_data[7] = 32'h7777_7777;
    unit_reg_valid  = 8'b0101_1111;
    unit_pred_valid = 8'b1001_0000;

    reset      = 1'b1;
    issue      = 1'b0;
    issue_unit = 3'd0;
    unit_done  = 8'h00;
    m_busy     = 8'h00;
    last_wb    = '{1'b0, 4'd0, 1'b0, 2'd0, 32'd0, 3'd0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_free_units", {24'd0, free_units}, 32'hFF);
    check("rst_wr_reg",     {31'd0, wr_reg},     32'd0);
    check("rst_wr_pred",    {31'd0, wr_pred},    32'd0);
    check("rst_wr_data",    wr_data,             32'd0);
    check("rst_wb_unit_id", {29'd0, wb_unit_id}, 32'd0);
    check("rst_unit_ack",   {24'd0, unit_ack},   32'd0);
    reset = 1'b0;

    vecs.push_back(mk("idle",          1'b0, 3'd0, 8'h00, 8'h00));
    vecs.push_back(mk("issue_u3",      1'b1, 3'd3, 8'h00, 8'h00));
    vecs.push_back(mk("done_u3",       1'b0, 3'd0, 8'h08, 8'h08));
    vecs.push_back(mk("stray_u2",      1'b0, 3'd0, 8'h04, 8'h00));
    vecs.push_back(mk("issue_u7",      1'b1, 3'd7, 8'h00, 8'h00));
    vecs.push_back(mk("done_u7_pred",  1'b0, 3'd0, 8'h80, 8'h80));
    vecs.push_back(mk("issue_u0",      1'b1, 3'd0, 8'h00, 8'h00));
    vecs.push_back(mk("issue_u6",      1'b1, 3'd6, 8'h00, 8'h00));
    vecs.push_back(mk("wrap_u0_first", 1'b0, 3'd0, 8'h41, 8'h01));
    vecs.push_back(mk("then_u6",       1'b0, 3'd0, 8'h40, 8'h40));
    vecs.push_back(mk("issue_u1",      1'b1, 3'd1, 8'h00, 8'h00));
    vecs.push_back(mk("issue_u4",      1'b1, 3'd4, 8'h00, 8'h00));
    vecs.push_back(mk("issue_u6b",     1'b1, 3'd6, 8'h00, 8'h00));
    vecs.push_back(mk("rr_146_a",      1'b0, 3'd0, 8'h52, 8'h02));
    vecs.push_back(mk("rr_146_b",      1'b0, 3'd0, 8'h50, 8'h10));
    vecs.push_back(mk("rr_146_c",      1'b0, 3'd0, 8'h40, 8'h40));
    vecs.push_back(mk("rr_146_idle",   1'b0, 3'd0, 8'h00, 8'h00));
    vecs.push_back(mk("issue_u5",      1'b1, 3'd5, 8'h00, 8'h00));
    vecs.push_back(mk("store_u5",      1'b0, 3'd0, 8'h20, 8'h20));
    vecs.push_back(mk("issue_u0b",     1'b1, 3'd0, 8'h00, 8'h00));
    vecs.push_back(mk("ack_issue_u0",  1'b1, 3'd0, 8'h01, 8'h01));
    vecs.push_back(mk("done_u0_again", 1'b0, 3'd0, 8'h01, 8'h01));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Three requesters kept pending: each winner is re-issued in the same cycle.
    applyStimulus(mk("fair_issue_u1", 1'b1, 3'd1, 8'h00, 8'h00));
    applyStimulus(mk("fair_issue_u4", 1'b1, 3'd4, 8'h00, 8'h00));
    applyStimulus(mk("fair_issue_u6", 1'b1, 3'd6, 8'h00, 8'h00));
    for (int c = 0; c < 6; c++) begin
`ifdef WB_ARB_FIXED_PRIORITY_EN
      applyStimulus(mk($sformatf("fair_%0d", c), 1'b1, 3'd1, 8'h52, 8'h02));
`else
      case (c % 3)
        0:       applyStimulus(mk($sformatf("fair_%0d", c), 1'b1, 3'd1, 8'h52, 8'h02));
        1:       applyStimulus(mk($sformatf("fair_%0d", c), 1'b1, 3'd4, 8'h52, 8'h10));
        default: applyStimulus(mk($sformatf("fair_%0d", c), 1'b1, 3'd6, 8'h52, 8'h40));
      endcase
`endif
    end

    // Reset in the middle of operation with three pending requests.
    applyStimulus(mk("pre_rst_u2", 1'b1, 3'd2, 8'h00, 8'h00));
    applyStimulus(mk("pre_rst_u3", 1'b1, 3'd3, 8'h00, 8'h00));
    applyStimulus(mk("pre_rst_u5", 1'b1, 3'd5, 8'h00, 8'h00));
    issue     = 1'b0;
    unit_done = 8'h2C;
    reset     = 1'b1;
    #1;
    check("mid_rst_unit_ack", {24'd0, unit_ack}, 32'd0);
    m_busy  = 8'h00;
    last_wb = '{1'b0, 4'd0, 1'b0, 2'd0, 32'd0, 3'd0};
    sb_q.push_back(last_wb);
    @(posedge clk);
    #1;
    checkOutput("mid_rst");
    reset = 1'b0;

    applyStimulus(mk("post_rst_stale", 1'b0, 3'd0, 8'h2C, 8'h00));
    applyStimulus(mk("post_rst_iss7",  1'b1, 3'd7, 8'h00, 8'h00));
    applyStimulus(mk("post_rst_iss0",  1'b1, 3'd0, 8'h00, 8'h00));
    applyStimulus(mk("post_rst_rr0",   1'b0, 3'd0, 8'h81, 8'h01));
    applyStimulus(mk("post_rst_u7",    1'b0, 3'd0, 8'h80, 8'h80));
    applyStimulus(mk("final_idle",     1'b0, 3'd0, 8'h00, 8'h00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
